// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, MDU sequencer state encoding and default parameter values.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int MDU_LAT_DEF = 4;
  localparam int CNT_W_DEF   = 3;

  // EX operand mux select: data_in0 = regfile, data_in1 = WB, data_in2 = MEM.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath (ID-stage decode in, hazard controls out) and
// the hazard controller.
// Timing contract: there is no valid/ready pair here. The decode fields are
// taken as valid every cycle, and stall_f/stall_d act as the back-pressure
// the datapath must honour on the following rising edge.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);

  // ID-stage decode
  logic [REG_AW-1:0] rs_d;
  logic [REG_AW-1:0] rt_d;
  logic              use_rs_d;
  logic              use_rt_d;
  logic [REG_AW-1:0] writereg_d;
  logic              regwrite_d;
  logic              memtoreg_d;
  logic              branch_d;
  logic              pcsrc_d;
  logic              mdu_op_d;
  logic              mdu_rd_d;

  // Hazard controls
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  fwd_sel_t          fwd_a_e;
  fwd_sel_t          fwd_b_e;
  logic              fwd_a_d;
  logic              fwd_b_d;
  logic              mdu_busy;

  // Debug visibility of the MDU sequencer state
  mdu_state_t        mdu_state;

  modport master (
    output rs_d, rt_d, use_rs_d, use_rt_d, writereg_d, regwrite_d,
           memtoreg_d, branch_d, pcsrc_d, mdu_op_d, mdu_rd_d,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           fwd_a_d, fwd_b_d, mdu_busy, mdu_state
  );

  modport slave (
    input  rs_d, rt_d, use_rs_d, use_rt_d, writereg_d, regwrite_d,
           memtoreg_d, branch_d, pcsrc_d, mdu_op_d, mdu_rd_d,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           fwd_a_d, fwd_b_d, mdu_busy, mdu_state
  );

endinterface

// File: rtl/hazard_ctrl_mdu_seq.sv
// MDU busy sequencer: IDLE/BUSY FSM with a countdown. Starts when a mult/div
// sits in EX and stays BUSY for MDU_LAT-1 cycles after that EX cycle.
module hazard_ctrl_mdu_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output mdu_state_t state
);

  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // State and countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: load the countdown on start, leave BUSY once it reaches 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          state_next = MDU_BUSY;
          cnt_next   = CNT_W'(MDU_LAT - 1);
        end
      end
      MDU_BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = MDU_IDLE;
        end
      end
      default: begin
        state_next = MDU_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state == MDU_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: keeps a shadow E/M/W copy of
// register-use info, derives EX/ID forwarding selects, load-use, branch and
// MDU stalls, and the F/D/E stall/flush controls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  hz
);

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
    logic              regwrite;
    logic              memtoreg;
    logic              mdu_op;
  } e_stage_t;

  typedef struct packed {
    logic [REG_AW-1:0] wr;
    logic              regwrite;
    logic              memtoreg;
  } m_stage_t;

  typedef struct packed {
    logic [REG_AW-1:0] wr;
    logic              regwrite;
  } w_stage_t;

  e_stage_t st_d;
  e_stage_t st_e;
  m_stage_t st_m;
  w_stage_t st_w;

  logic     lwstall;
  logic     brstall;
  logic     mdustall;
  logic     stall;
  logic     mdu_busy;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  // Register $0 is hard-wired, so it never produces a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a,
                               input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Gather the ID-stage decode into the shape held by the E shadow.
  always_comb begin
    st_d.rs       = hz.rs_d;
    st_d.rt       = hz.rt_d;
    st_d.wr       = hz.writereg_d;
    st_d.regwrite = hz.regwrite_d;
    st_d.memtoreg = hz.memtoreg_d;
    st_d.mdu_op   = hz.mdu_op_d;
  end

  // Shadow pipeline; a stalled ID instruction becomes a bubble in E.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_e <= '0;
      st_m <= '0;
      st_w <= '0;
    end else begin
      st_e <= stall ? e_stage_t'('0) : st_d;
      st_m <= '{wr: st_e.wr, regwrite: st_e.regwrite, memtoreg: st_e.memtoreg};
      st_w <= '{wr: st_m.wr, regwrite: st_m.regwrite};
    end
  end

  hazard_ctrl_mdu_seq #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq (
    .clk   (clk),
    .rst   (rst),
    .start (st_e.mdu_op),
    .busy  (mdu_busy),
    .state (hz.mdu_state)
  );

  // EX forwarding: the youngest producer (MEM) wins over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (st_m.regwrite && hit(st_e.rs, st_m.wr))      fwd_a = FWD_MEM;
    else if (st_w.regwrite && hit(st_e.rs, st_w.wr)) fwd_a = FWD_WB;
    if (st_m.regwrite && hit(st_e.rt, st_m.wr))      fwd_b = FWD_MEM;
    else if (st_w.regwrite && hit(st_e.rt, st_w.wr)) fwd_b = FWD_WB;
  end

  // Stall sources: load-use, branch operand not ready in ID, MDU in flight.
  always_comb begin
    lwstall  = st_e.memtoreg &&
               ((hz.use_rs_d && hit(hz.rs_d, st_e.wr)) ||
                (hz.use_rt_d && hit(hz.rt_d, st_e.wr)));
    brstall  = hz.branch_d &&
               ((st_e.regwrite && (hit(hz.rs_d, st_e.wr) || hit(hz.rt_d, st_e.wr))) ||
                (st_m.memtoreg && (hit(hz.rs_d, st_m.wr) || hit(hz.rt_d, st_m.wr))));
    mdustall = mdu_busy && (hz.mdu_op_d || hz.mdu_rd_d);
    stall    = lwstall || brstall || mdustall;
  end

  // Drive the control outputs; a stalled branch defers its flush.
  always_comb begin
    hz.stall_f  = stall;
    hz.stall_d  = stall;
    hz.flush_e  = stall;
    hz.flush_d  = hz.pcsrc_d && !stall;
    hz.fwd_a_e  = fwd_a;
    hz.fwd_b_e  = fwd_b;
    hz.fwd_a_d  = st_m.regwrite && hit(hz.rs_d, st_m.wr);
    hz.fwd_b_d  = st_m.regwrite && hit(hz.rt_d, st_m.wr);
    hz.mdu_busy = mdu_busy;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl against an instruction-level model of the
// E/M/W pipeline and the MDU busy window.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;
  localparam int N_CYC   = 3000;
  localparam int W       = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

  hazard_ctrl #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int rs;
    int rt;
    int wr;
    bit regwrite;
    bit memtoreg;
    bit mdu_op;
  } instr_t;

  instr_t pipe[3];       // 0 = EX, 1 = MEM, 2 = WB
  instr_t cur;           // instruction presented in ID this cycle
  bit     use_rs, use_rt, branch, pcsrc, mdu_rd;
  int     busy_left;     // cycles of MDU occupancy still to come
  bit     exp_stall;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic instr_t bubble();
    instr_t b;
    b = '{rs: 0, rt: 0, wr: 0, regwrite: 1'b0, memtoreg: 1'b0, mdu_op: 1'b0};
    return b;
  endfunction

  // Does an instruction in a later stage produce the value of register r?
  function automatic bit same_reg(int wr, int r);
    return (r != 0) && (wr == r);
  endfunction

  function automatic int fwd_ex(int r);
    if (pipe[1].regwrite && same_reg(pipe[1].wr, r)) return 2;
    if (pipe[2].regwrite && same_reg(pipe[2].wr, r)) return 1;
    return 0;
  endfunction

  // Expected outputs for the current cycle, packed and pushed to exp_q.
  task automatic model_expect();
    bit lw, br, md;
    bit [1:0] fa, fb;
    bit fad, fbd, busy;
    lw = pipe[0].memtoreg &&
         ((use_rs && same_reg(pipe[0].wr, cur.rs)) ||
          (use_rt && same_reg(pipe[0].wr, cur.rt)));
    br = branch &&
         ((pipe[0].regwrite && (same_reg(pipe[0].wr, cur.rs) || same_reg(pipe[0].wr, cur.rt))) ||
          (pipe[1].memtoreg && (same_reg(pipe[1].wr, cur.rs) || same_reg(pipe[1].wr, cur.rt))));
    busy = (busy_left > 0);
    md   = busy && (cur.mdu_op || mdu_rd);
    exp_stall = lw || br || md;
    fa  = 2'(fwd_ex(pipe[0].rs));
    fb  = 2'(fwd_ex(pipe[0].rt));
    fad = pipe[1].regwrite && same_reg(pipe[1].wr, cur.rs);
    fbd = pipe[1].regwrite && same_reg(pipe[1].wr, cur.rt);
    exp_q.push_back({fa, fb, fad, fbd, exp_stall, exp_stall,
                     pcsrc && !exp_stall, exp_stall, busy});
  endtask

  // Advance the model by one clock edge.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
      busy_left = 0;
    end else begin
      if (busy_left > 0)       busy_left = busy_left - 1;
      else if (pipe[0].mdu_op) busy_left = MDU_LAT - 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = exp_stall ? bubble() : cur;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    hz.rs_d       = REG_AW'(cur.rs);
    hz.rt_d       = REG_AW'(cur.rt);
    hz.writereg_d = REG_AW'(cur.wr);
    hz.regwrite_d = cur.regwrite;
    hz.memtoreg_d = cur.memtoreg;
    hz.mdu_op_d   = cur.mdu_op;
    hz.use_rs_d   = use_rs;
    hz.use_rt_d   = use_rt;
    hz.branch_d   = branch;
    hz.pcsrc_d    = pcsrc;
    hz.mdu_rd_d   = mdu_rd;
  endtask

  task automatic drive_idle();
    cur    = bubble();
    use_rs = 1'b0;
    use_rt = 1'b0;
    branch = 1'b0;
    pcsrc  = 1'b0;
    mdu_rd = 1'b0;
    apply_inputs();
  endtask

  // Small register range so dependencies and $0 cases occur often.
  task automatic drive_random();
    cur.rs       = int'($urandom_range(0, 3));
    cur.rt       = int'($urandom_range(0, 3));
    cur.wr       = int'($urandom_range(0, 3));
    cur.memtoreg = ($urandom_range(0, 3) == 0);
    cur.regwrite = cur.memtoreg || ($urandom_range(0, 9) < 6);
    cur.mdu_op   = ($urandom_range(0, 9) == 0);
    use_rs       = ($urandom_range(0, 4) != 0);
    use_rt       = ($urandom_range(0, 4) != 0);
    branch       = ($urandom_range(0, 4) == 0);
    pcsrc        = ($urandom_range(0, 3) == 0);
    mdu_rd       = ($urandom_range(0, 6) == 0);
    apply_inputs();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("fwd_a_e",  32'(hz.fwd_a_e),  32'(e[10:9]));
    check("fwd_b_e",  32'(hz.fwd_b_e),  32'(e[8:7]));
    check("fwd_a_d",  32'(hz.fwd_a_d),  32'(e[6]));
    check("fwd_b_d",  32'(hz.fwd_b_d),  32'(e[5]));
    check("stall_f",  32'(hz.stall_f),  32'(e[4]));
    check("stall_d",  32'(hz.stall_d),  32'(e[3]));
    check("flush_d",  32'(hz.flush_d),  32'(e[2]));
    check("flush_e",  32'(hz.flush_e),  32'(e[1]));
    check("mdu_busy", 32'(hz.mdu_busy), 32'(e[0]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    busy_left = 0;
    drive_idle();
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 49) == 0);
      if (cyc < 4) drive_idle();
      else         drive_random();
      #1;
      model_expect();
      check_outputs();
      @(posedge clk);
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
